// File: rtl/frame_buf_mem_responder_pkg.sv
// frame_buf_pkg: shared widths, opcodes and request record for the frame-buffer responder
package frame_buf_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;
    // Field order {op, addr, wben, data} gives a 53-bit request
    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [LANES-1:0]  wben;
        logic [DATA_W-1:0] data;
    } req_t;
endpackage

// File: rtl/frame_buf_mem_responder_if.sv
// frame_buf_mem_responder_if: client->responder request handshake plus read-data broadcast
//   req_in_*     : request valid/op/addr/byte-enables/data driven by the client
//   req_out_rtr  : responder ready
//   bcast_out_*  : one-cycle read-data broadcast
interface frame_buf_mem_responder_if;
    import frame_buf_pkg::*;
    logic              req_in_rts;
    logic              req_out_rtr;
    logic              req_in_op;
    logic [ADDR_W-1:0] req_in_addr;
    logic [LANES-1:0]  req_in_wben;
    logic [DATA_W-1:0] req_in_data;
    logic [DATA_W-1:0] bcast_out_data;
    logic              bcast_out_xfc;
    modport master (
        output req_in_rts, req_in_op, req_in_addr, req_in_wben, req_in_data,
        input  req_out_rtr, bcast_out_data, bcast_out_xfc
    );
    modport slave (
        input  req_in_rts, req_in_op, req_in_addr, req_in_wben, req_in_data,
        output req_out_rtr, bcast_out_data, bcast_out_xfc
    );
endinterface

// File: rtl/frame_buf_mem_responder_req_fifo2.sv
// req_fifo2: 2-entry in-order request buffer with synchronous active-low clear
//   push_i/din_i : enqueue (caller must not push while full_o)
//   pop_i/dout_o : dequeue head (ignored while empty_o)
//   count_d_o    : occupancy after this edge, used for registered ready
module req_fifo2
    import frame_buf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_,
    input  logic       push_i,
    input  req_t       din_i,
    input  logic       pop_i,
    output req_t       dout_o,
    output logic [1:0] count_d_o,
    output logic       empty_o,
    output logic       full_o
);
    req_t       ent_q [2];
    logic       wr_q, rd_q;
    logic [1:0] count_q;
    logic       do_push, do_pop;
    assign empty_o   = count_q == 2'd0;
    assign full_o    = count_q == 2'd2;
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;
    assign count_d_o = count_q + {1'b0, do_push} - {1'b0, do_pop};
    assign dout_o    = ent_q[rd_q];
    always_ff @(posedge clk) begin
        if (!rst_) begin
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wr_q    <= wr_q ^ do_push;
            rd_q    <= rd_q ^ do_pop;
            count_q <= count_d_o;
        end
    end
    always_ff @(posedge clk)
        if (do_push) ent_q[wr_q] <= din_i;
endmodule

// File: rtl/frame_buf_mem_responder.sv
// frame_buf_mem_responder: in-order byte-enabled frame-buffer RAM target with read broadcast
//   clk, rst_   : clock, synchronous active-low reset
//   bus         : request handshake and read broadcast (slave side)
//   mem_is_idle : buffer empty and no read in flight
//   err_oob     : sticky, an out-of-range request was accepted
module frame_buf_mem_responder
    import frame_buf_pkg::*;
#(
    parameter int MEM_WORDS  = 4096,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_,
    frame_buf_mem_responder_if.slave   bus,
    output logic                       mem_is_idle,
    output logic                       err_oob
);
    localparam int AW = $clog2(MEM_WORDS);
    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [DATA_W-1:0] ram_q, data_q;
    logic              rtr_q, rd_pend_q, rd_oob_q, xfc_q, err_q;
    logic              push, pop, fifo_empty, fifo_full, head_oob, in_oob, we;
    logic [1:0]        count_d;
    req_t              head;
    logic [AW-1:0]     idx;
    assign push     = bus.req_in_rts & rtr_q & ~fifo_full;
    assign pop      = ~fifo_empty;
    assign in_oob   = {1'b0, bus.req_in_addr} >= (ADDR_W+1)'(MEM_WORDS);
    assign head_oob = {1'b0, head.addr} >= (ADDR_W+1)'(MEM_WORDS);
    assign idx      = head.addr[AW-1:0];
    // The reset edge must not retire the head entry, so RAM writes are gated by rst_
    assign we       = rst_ & pop & (head.op == OP_WRITE) & ~head_oob;
    req_fifo2 u_fifo (
        .clk       (clk),
        .rst_      (rst_),
        .push_i    (push),
        .din_i     ({bus.req_in_op, bus.req_in_addr, bus.req_in_wben, bus.req_in_data}),
        .pop_i     (pop),
        .dout_o    (head),
        .count_d_o (count_d),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (we && head.wben[i]) mem[idx][8*i +: 8] <= head.data[8*i +: 8];
        ram_q <= mem[idx];
    end
    // Read pipeline: pop edge captures RAM into ram_q, next edge moves it to the broadcast register
    always_ff @(posedge clk) begin
        if (!rst_) begin
            rtr_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_oob_q  <= 1'b0;
            xfc_q     <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            rtr_q     <= count_d < 2'(FIFO_DEPTH);
            rd_pend_q <= pop & (head.op == OP_READ);
            rd_oob_q  <= head_oob;
            xfc_q     <= rd_pend_q;
            data_q    <= rd_pend_q ? (rd_oob_q ? '0 : ram_q) : data_q;
            err_q     <= err_q | (push & in_oob);
        end
    end
    assign bus.req_out_rtr    = rtr_q;
    assign bus.bcast_out_xfc  = xfc_q;
    assign bus.bcast_out_data = data_q;
    assign mem_is_idle        = fifo_empty & ~rd_pend_q;
    assign err_oob            = err_q;
endmodule

// File: tb/tb_frame_buf_mem_responder.sv
// tb_frame_buf_mem_responder: directed table-driven bench for frame_buf_mem_responder
module tb_frame_buf_mem_responder;
    import frame_buf_pkg::*;
    typedef struct {
        logic        op;
        logic [15:0] addr;
        logic [3:0]  wben;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    localparam int NV = 22;
    logic clk, rst_, idle, err;
    int   n_cmp, n_bad;
    logic exp_err;
    vec_t tv [NV];
    logic [31:0] mdl [4];
    frame_buf_mem_responder_if bus ();
    frame_buf_mem_responder #(.MEM_WORDS(4096), .FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst_        (rst_),
        .bus         (bus),
        .mem_is_idle (idle),
        .err_oob     (err)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    task automatic drive(input logic rts, input logic op, input logic [15:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        bus.req_in_rts  = rts;
        bus.req_in_op   = op;
        bus.req_in_addr = a;
        bus.req_in_wben = be;
        bus.req_in_data = d;
    endtask
    // Streams tv[s..s+n-1] one per cycle; a read issued at step i must broadcast after step i+2
    task automatic run_vecs(input int s, input int n);
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) drive(1'b1, tv[s+i].op, tv[s+i].addr, tv[s+i].wben, tv[s+i].data);
            else       drive(1'b0, OP_READ, 16'h0, 4'h0, 32'h0);
            step();
            if (i < n) begin
                chk("rtr_stream", {31'b0, bus.req_out_rtr}, 32'd1);
                if (tv[s+i].addr >= 16'd4096) exp_err = 1'b1;
            end
            chk("err_oob", {31'b0, err}, {31'b0, exp_err});
            if (i >= 2) begin
                chk($sformatf("xfc_vec%0d", s+i-2), {31'b0, bus.bcast_out_xfc}, {31'b0, tv[s+i-2].op});
                if (tv[s+i-2].op) chk($sformatf("rdata_vec%0d", s+i-2), bus.bcast_out_data, tv[s+i-2].exp);
            end else begin
                chk("xfc_quiet", {31'b0, bus.bcast_out_xfc}, 32'd0);
            end
        end
        chk("idle_after", {31'b0, idle}, 32'd1);
    endtask
    initial begin
        tv[0]  = '{OP_WRITE, 16'h0005, 4'hF, 32'hFFFF_FFFF, 32'h0};
        tv[1]  = '{OP_WRITE, 16'h0005, 4'h4, 32'h00AB_0000, 32'h0};
        tv[2]  = '{OP_READ,  16'h0005, 4'h0, 32'h0,         32'hFFAB_FFFF};
        tv[3]  = '{OP_WRITE, 16'h0000, 4'hF, 32'h1122_3344, 32'h0};
        tv[4]  = '{OP_WRITE, 16'h1000, 4'hF, 32'h1234_5678, 32'h0};
        tv[5]  = '{OP_READ,  16'h1000, 4'h0, 32'h0,         32'h0};
        tv[6]  = '{OP_READ,  16'h0000, 4'h0, 32'h0,         32'h1122_3344};
        tv[7]  = '{OP_WRITE, 16'h0007, 4'hF, 32'hAABB_CCDD, 32'h0};
        tv[8]  = '{OP_WRITE, 16'h0007, 4'h0, 32'h0,         32'h0};
        tv[9]  = '{OP_READ,  16'h0007, 4'h0, 32'h0,         32'hAABB_CCDD};
        tv[10] = '{OP_WRITE, 16'h0007, 4'h9, 32'h5566_7788, 32'h0};
        tv[11] = '{OP_READ,  16'h0007, 4'h0, 32'h0,         32'h55BB_CC88};
        tv[12] = '{OP_READ,  16'h0005, 4'h0, 32'h0,         32'hFFAB_FFFF};
        tv[13] = '{OP_WRITE, 16'hFFFF, 4'hF, 32'h0000_0001, 32'h0};
        tv[14] = '{OP_READ,  16'h0000, 4'h0, 32'h0,         32'h1122_3344};
        tv[15] = '{OP_WRITE, 16'h0FFF, 4'hF, 32'hCAFE_BABE, 32'h0};
        tv[16] = '{OP_READ,  16'h0FFF, 4'h0, 32'h0,         32'hCAFE_BABE};
        tv[17] = '{OP_READ,  16'h0007, 4'h0, 32'h0,         32'h55BB_CC88};
        tv[18] = '{OP_WRITE, 16'h0009, 4'hF, 32'h0102_0304, 32'h0};
        tv[19] = '{OP_READ,  16'h0009, 4'h0, 32'h0,         32'h0102_0304};
        tv[20] = '{OP_READ,  16'h0005, 4'h0, 32'h0,         32'hFFAB_FFFF};
        tv[21] = '{OP_READ,  16'h000B, 4'h0, 32'h0,         32'h0BAD_F00D};
        n_cmp = 0;
        n_bad = 0;
        exp_err = 1'b0;
        rst_ = 1'b0;
        drive(1'b0, OP_WRITE, 16'h0, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rtr", {31'b0, bus.req_out_rtr}, 32'd0);
            chk("rst_xfc", {31'b0, bus.bcast_out_xfc}, 32'd0);
            chk("rst_err", {31'b0, err}, 32'd0);
            chk("rst_idle", {31'b0, idle}, 32'd1);
        end
        chk("rst_data", bus.bcast_out_data, 32'h0);
        rst_ = 1'b1;
        step();
        chk("rtr_after_release", {31'b0, bus.req_out_rtr}, 32'd1);
        run_vecs(0, 17);
        for (int k = 0; k < 240; k++) begin
            drive(1'b1, OP_WRITE, 16'((k >> 2) & 3), 4'(1 << (k & 3)), {4{8'(k)}});
            mdl[(k >> 2) & 3][8*(k & 3) +: 8] = 8'(k);
            step();
            chk("stream_rtr", {31'b0, bus.req_out_rtr}, 32'd1);
        end
        for (int r = 0; r < 6; r++) begin
            if (r < 4) drive(1'b1, OP_READ, 16'(r), 4'h0, 32'h0);
            else       drive(1'b0, OP_READ, 16'h0, 4'h0, 32'h0);
            step();
            if (r < 4) chk("stream_rtr_rd", {31'b0, bus.req_out_rtr}, 32'd1);
            if (r >= 2) begin
                chk($sformatf("stream_xfc%0d", r-2), {31'b0, bus.bcast_out_xfc}, 32'd1);
                chk($sformatf("stream_data%0d", r-2), bus.bcast_out_data, mdl[r-2]);
            end else begin
                chk("stream_xfc_quiet", {31'b0, bus.bcast_out_xfc}, 32'd0);
            end
        end
        step();
        chk("stream_xfc_end", {31'b0, bus.bcast_out_xfc}, 32'd0);
        chk("err_sticky", {31'b0, err}, 32'd1);
        run_vecs(17, 3);
        drive(1'b1, OP_WRITE, 16'h000B, 4'hF, 32'h0BAD_F00D);
        step();
        drive(1'b1, OP_READ, 16'h0005, 4'h0, 32'h0);
        step();
        drive(1'b0, OP_READ, 16'h0, 4'h0, 32'h0);
        rst_ = 1'b0;
        step();
        chk("midrst_xfc", {31'b0, bus.bcast_out_xfc}, 32'd0);
        chk("midrst_rtr", {31'b0, bus.req_out_rtr}, 32'd0);
        chk("midrst_idle", {31'b0, idle}, 32'd1);
        chk("midrst_err", {31'b0, err}, 32'd0);
        rst_ = 1'b1;
        exp_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_xfc", {31'b0, bus.bcast_out_xfc}, 32'd0);
            chk("post_rst_idle", {31'b0, idle}, 32'd1);
        end
        chk("post_rst_rtr", {31'b0, bus.req_out_rtr}, 32'd1);
        run_vecs(20, 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/frame_buf_mem_responder.md
# frame_buf_mem_responder

Target side of the client→arbiter memory request interface. Accepts byte-enabled write and read requests on an rts/rtr handshake, performs them in order against a word-wide frame-buffer RAM, and returns read data as a one-cycle broadcast. It sits directly below the arbiter, so drawing engines (fill-rect generator and later engines) talk to memory through it.

## Interface
- MEM_WORDS, 4096: number of 32-bit words implemented; valid addresses are 0..MEM_WORDS-1.
- FIFO_DEPTH, 2: request buffer entries. Fixed at 2; other values are unsupported.
- clk  in  1  sole clock; all logic on the rising edge.
- rst_  in  1  reset, synchronous, active-low.
- req_in_rts  in  1  request valid.
- req_out_rtr  out  1  responder can accept a request this cycle (registered).
- req_in_op  in  1  0 = write, 1 = read.
- req_in_addr  in  16  word address.
- req_in_wben  in  4  byte-lane write enables; bit i selects data[8i+7:8i]. Ignored for reads.
- req_in_data  in  32  write data. Ignored for reads.
- bcast_out_data  out  32  read data, valid only while bcast_out_xfc is 1.
- bcast_out_xfc  out  1  one-cycle strobe, one per completed read.
- mem_is_idle  out  1  buffer empty and no read in flight.
- err_oob  out  1  sticky flag: a request with address >= MEM_WORDS was accepted.

## Operation
- Transfer: `xfc = req_in_rts & req_out_rtr`. On each transfer, {op, addr, wben, data} is pushed into the 2-entry in-order buffer.
- Execute stage: when the buffer is non-empty, the head entry is popped and executed, one per cycle.
  - Write: for each i with wben[i] = 1, RAM[addr] byte i gets data byte i. Other bytes are unchanged. A write with wben = 0 is a no-op that still consumes the slot.
  - Read: RAM[addr] is registered onto bcast_out_data, and bcast_out_xfc is asserted in the following cycle.
- Ordering: strictly in acceptance order. A read after a write to the same address returns the written bytes.
- Out-of-range address (>= MEM_WORDS):
  - Writes are dropped.
  - Reads return 32'h0 with a normal xfc strobe.
  - err_oob sets and holds until reset.
- Arithmetic: addr is compared unsigned against MEM_WORDS. There is no address wrap.
- Reset values:
  - req_out_rtr = 0, bcast_out_xfc = 0, bcast_out_data = 0, err_oob = 0, mem_is_idle = 1.
  - Buffer count = 0.
  - RAM contents are not reset.
- Reset mid-operation: buffered requests and in-flight reads are discarded and no xfc is issued. A write already executed before the reset edge stays in RAM.

## Timing
- req_out_rtr next value is `(count_next < 2) & rst_`.
  - It is 0 in the reset cycle and 1 in the first cycle after reset releases.
  - It drops in the cycle after the buffer becomes full.
- Push and pop may happen on the same edge; count is then unchanged.
- No push is accepted while full: rtr is 0 then, so rts is ignored.
- Latency, read accepted at edge N into an empty buffer:
  - executes at edge N+1;
  - bcast_out_xfc = 1 during cycle N+2, i.e. after edge N+2 (data registered at N+2).
- Latency, write accepted at edge N into an empty buffer: RAM is updated at edge N+1.
- Sustained throughput: one request per cycle with rts held high. Rtr stays 1 because push and pop balance.
- Back-to-back reads: xfc is high for consecutive cycles, one data word per cycle, in request order.
- mem_is_idle is combinational: `count == 0 & !read_pending`.

## Structure
- Package frame_buf_pkg:
  - OP_WRITE = 1'b0, OP_READ = 1'b1;
  - ADDR_W = 16, DATA_W = 32, LANES = 4;
  - the request struct/concatenation order {op, addr, wben, data} = 53 bits.
- Sub-module req_fifo2: 2-entry in-order request buffer with push/pop, count, full/empty, and synchronous active-low clear.
- RAM is inferred in the top as a byte-lane-enabled array of MEM_WORDS × 32. Its read data is registered.

## Test plan
- Reset release: hold rst_ = 0 for 3 cycles.
  - Required: rtr = 0, xfc = 0, err_oob = 0, idle = 1 during reset.
  - Required: rtr = 1 on the first cycle after release.
- Partial write:
  - Stimulus: write addr 5, data 32'hFFFF_FFFF, wben 4'hF; then write addr 5, data 32'h00AB_0000, wben 4'h4; then read addr 5.
  - Required: xfc two cycles after the read is accepted, with data 32'hFFAB_FFFF.
- Streaming: hold rts = 1 for 240 consecutive fill-rect-style writes (wben walking 1,2,4,8), then 4 reads of addresses 0..3.
  - Required: rtr never drops.
  - Required: 4 consecutive xfc cycles with data matching the per-lane model.
- Backpressure: feed 3 requests on consecutive cycles while the execute stage is forced busy by a pending read pattern, then sample.
  - Required: rtr = 0 when count = 2.
  - Required: no request is lost or duplicated.
  - Required: results match a scoreboard.
- Out-of-range: MEM_WORDS = 4096, write addr 16'h1000 data 32'h1234_5678, then read addr 16'h1000.
  - Required: read returns 32'h0 with xfc.
  - Required: err_oob = 1 and stays 1.
  - Required: addr 0 is unchanged.
- Reset mid-flight: accept a read, assert rst_ on the next edge.
  - Required: no xfc.
  - Required: after release, idle = 1 and a fresh read returns the correct data.
